// File: rtl/unidade_controle_seed.sv
// Seed-selection sequencer: a Moore FSM that clears the seed datapath,
// gates the seed-advance button during selection, registers the chosen
// seed on confirm or on a selection timeout, and then holds the game in
// the playing state until a new game is requested.
module unidade_controle_seed #(
  parameter int TIMEOUT = 16,
  parameter int TW      = $clog2(TIMEOUT)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       confirmar,
  input  logic       novo_jogo,
  input  logic       botao,
  output logic       botao_seed,
  output logic       rst_dp,
  output logic       zera_CS,
  output logic       e_seed_reg,
  output logic       pronto,
  output logic       timeout,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL    = 4'h0,
    PREPARA    = 4'h1,
    ESCOLHA    = 4'h2,
    ESPERA_ROM = 4'h3,
    REGISTRA   = 4'h4,
    JOGO       = 4'h5
  } estado_t;

  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  estado_t       state;
  estado_t       next_state;
  logic [TW-1:0] timer;
  logic          iniciar_q;
  logic          confirmar_q;
  logic          novo_jogo_q;

  // Rising-edge pulses: a held button level advances the FSM only once.
  logic iniciar_pulse;
  logic confirmar_pulse;
  logic novo_jogo_pulse;

  assign iniciar_pulse   = iniciar   & ~iniciar_q;
  assign confirmar_pulse = confirmar & ~confirmar_q;
  assign novo_jogo_pulse = novo_jogo & ~novo_jogo_q;

  logic timer_done;
  assign timer_done = (timer == TIMER_LAST);

  // State register, selection timer, timeout flag and button history.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values and the update order inside the block is irrelevant.
    if (reset) begin
      state       <= INICIAL;
      timer       <= '0;
      timeout     <= 1'b0;
      iniciar_q   <= 1'b0;
      confirmar_q <= 1'b0;
      novo_jogo_q <= 1'b0;
    end else begin
      state       <= next_state;
      iniciar_q   <= iniciar;
      confirmar_q <= confirmar;
      novo_jogo_q <= novo_jogo;
      case (state)
        INICIAL: timeout <= 1'b0;
        PREPARA: begin
          timer   <= '0;
          timeout <= 1'b0;
        end
        ESCOLHA: begin
          timer <= timer + TW'(1);
          // Auto-confirm flags the seed only when the player did not confirm.
          if (timer_done && !confirmar_pulse) timeout <= 1'b1;
        end
        JOGO: if (novo_jogo_pulse) timeout <= 1'b0;
        default: ;
      endcase
    end
  end

  // Next-state logic; unused encodings fall back to INICIAL.
  always_comb begin
    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    next_state = INICIAL;
    case (state)
      INICIAL:    next_state = iniciar_pulse ? PREPARA : INICIAL;
      PREPARA:    next_state = ESCOLHA;
      ESCOLHA:    next_state = (confirmar_pulse || timer_done) ? ESPERA_ROM : ESCOLHA;
      ESPERA_ROM: next_state = REGISTRA;
      REGISTRA:   next_state = JOGO;
      JOGO:       next_state = novo_jogo_pulse ? PREPARA : JOGO;
      default:    next_state = INICIAL;
    endcase
  end

  // Moore outputs decoded from the registered state; only the button gate
  // and the reset term of rst_dp see inputs directly.
  always_comb begin
    botao_seed = (state == ESCOLHA) & botao;
    rst_dp     = reset | (state == PREPARA);
    zera_CS    = (state == PREPARA);
    e_seed_reg = (state == REGISTRA);
    pronto     = (state == JOGO);
    db_estado  = state;
  end

endmodule

// File: tb/tb_unidade_controle_seed.sv
// Bench for unidade_controle_seed: directed scenarios plus a randomized run,
// all compared against a cycle-level behavioural model of the game flow.
module tb_unidade_controle_seed;

  localparam int TIMEOUT = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic       confirmar = 1'b0;
  logic       novo_jogo = 1'b0;
  logic       botao = 1'b0;
  logic       botao_seed;
  logic       rst_dp;
  logic       zera_CS;
  logic       e_seed_reg;
  logic       pronto;
  logic       timeout;
  logic [3:0] db_estado;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  unidade_controle_seed #(.TIMEOUT(TIMEOUT)) dut (
    .clock      (clock),
    .reset      (reset),
    .iniciar    (iniciar),
    .confirmar  (confirmar),
    .novo_jogo  (novo_jogo),
    .botao      (botao),
    .botao_seed (botao_seed),
    .rst_dp     (rst_dp),
    .zera_CS    (zera_CS),
    .e_seed_reg (e_seed_reg),
    .pronto     (pronto),
    .timeout    (timeout),
    .db_estado  (db_estado)
  );

  always #5 clock = ~clock;

  // Behavioural model: game phase, cycles spent selecting, auto-confirm flag.
  int m_phase = 0;
  int m_sel   = 0;
  bit m_to    = 1'b0;
  bit pv_i = 1'b0, pv_c = 1'b0, pv_n = 1'b0;

  always @(posedge clock) begin
    if (reset) begin
      m_phase <= 0; m_sel <= 0; m_to <= 1'b0;
      pv_i <= 1'b0; pv_c <= 1'b0; pv_n <= 1'b0;
    end else begin
      pv_i <= iniciar; pv_c <= confirmar; pv_n <= novo_jogo;
      case (m_phase)
        0: if (iniciar && !pv_i) m_phase <= 1;
        1: begin m_phase <= 2; m_sel <= 0; m_to <= 1'b0; end
        2: begin
          m_sel <= m_sel + 1;
          if (confirmar && !pv_c) m_phase <= 3;
          else if (m_sel + 1 == TIMEOUT) begin m_phase <= 3; m_to <= 1'b1; end
        end
        3: m_phase <= 4;
        4: m_phase <= 5;
        5: if (novo_jogo && !pv_n) begin m_phase <= 1; m_to <= 1'b0; end
        default: m_phase <= 0;
      endcase
    end
  end

  // Lockstep comparison of every output against the model, mid low phase.
  always @(negedge clock) begin
    logic [9:0] exp_v, act_v;
    #3;
    if (mon_en) begin
      exp_v = {4'(m_phase), (m_phase == 2) && botao, reset || (m_phase == 1),
               m_phase == 1, m_phase == 4, m_phase == 5, m_to};
      act_v = {db_estado, botao_seed, rst_dp, zera_CS, e_seed_reg, pronto, timeout};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL model_lockstep t=%0t actual=%b expected=%b", $time, act_v, exp_v);
      end
    end
  end

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    mon_en = 1'b1;
    cyc();
    checks++;
    if ({db_estado, rst_dp, botao_seed, zera_CS, e_seed_reg, pronto, timeout} !== 10'b0000_1_00000) begin
      errors++;
      $display("FAIL reset_state actual=%h/%b expected=0/rst_dp=1 others 0", db_estado, rst_dp);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (rst_dp !== 1'b0) begin errors++; $display("FAIL reset_release rst_dp actual=%b expected=0", rst_dp); end
    cyc();
  endtask

  task automatic test_start();
    logic [3:0] exp_st [3] = '{4'h1, 4'h2, 4'h2};
    iniciar = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (db_estado !== exp_st[i] || rst_dp !== (i == 0) || zera_CS !== (i == 0)) begin
        errors++;
        $display("FAIL start_seq[%0d] actual st=%h rst_dp=%b zera=%b expected st=%h pulse=%b",
                 i, db_estado, rst_dp, zera_CS, exp_st[i], i == 0);
      end
    end
    iniciar = 1'b0;
  endtask

  task automatic test_confirm();
    for (int i = 0; i < 6; i++) begin
      botao = ~botao;
      #1;
      checks++;
      if (botao_seed !== botao) begin
        errors++;
        $display("FAIL botao_gate[%0d] actual=%b expected=%b", i, botao_seed, botao);
      end
      cyc();
    end
    confirmar = 1'b1;
    cyc();
    checks++;
    if (db_estado !== 4'h3 || timeout !== 1'b0) begin
      errors++; $display("FAIL confirm_m actual st=%h to=%b expected st=3 to=0", db_estado, timeout);
    end
    confirmar = 1'b0;
    cyc();
    checks++;
    if (db_estado !== 4'h4 || e_seed_reg !== 1'b1) begin
      errors++; $display("FAIL confirm_m1 actual st=%h e=%b expected st=4 e=1", db_estado, e_seed_reg);
    end
    cyc();
    checks++;
    if (db_estado !== 4'h5 || pronto !== 1'b1 || e_seed_reg !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL confirm_m2 actual st=%h p=%b e=%b to=%b expected st=5 p=1 e=0 to=0",
               db_estado, pronto, e_seed_reg, timeout);
    end
  endtask

  // Counts cycles spent in selection (first one already observed) until it leaves.
  task automatic count_selection(output int n);
    n = 1;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (db_estado == 4'h2) n++;
      else break;
    end
  endtask

  task automatic test_timeout();
    int n;
    novo_jogo = 1'b1;
    cyc();
    novo_jogo = 1'b0;
    cyc();
    botao = 1'b1;
    count_selection(n);
    checks++;
    if (n !== TIMEOUT || db_estado !== 4'h3 || timeout !== 1'b1) begin
      errors++;
      $display("FAIL auto_confirm actual cycles=%0d st=%h to=%b expected cycles=%0d st=3 to=1",
               n, db_estado, timeout, TIMEOUT);
    end
    #1;
    checks++;
    if (botao_seed !== 1'b0) begin errors++; $display("FAIL gate_after_sel actual=%b expected=0", botao_seed); end
    cyc();
    cyc();
    checks++;
    if (db_estado !== 4'h5 || pronto !== 1'b1 || timeout !== 1'b1) begin
      errors++; $display("FAIL timeout_jogo actual st=%h p=%b to=%b expected st=5 p=1 to=1", db_estado, pronto, timeout);
    end
    botao = 1'b0;
  endtask

  task automatic test_jogo_ignore();
    for (int i = 0; i < 8; i++) begin
      botao = 1'($urandom); confirmar = (i % 2 == 0); iniciar = (i % 3 == 0);
      cyc();
      checks++;
      if (db_estado !== 4'h5 || botao_seed !== 1'b0 || e_seed_reg !== 1'b0) begin
        errors++;
        $display("FAIL jogo_ignore[%0d] actual st=%h bs=%b e=%b expected st=5 bs=0 e=0",
                 i, db_estado, botao_seed, e_seed_reg);
      end
    end
    botao = 1'b0; confirmar = 1'b0; iniciar = 1'b0;
    novo_jogo = 1'b1;
    cyc();
    checks++;
    if (db_estado !== 4'h1 || rst_dp !== 1'b1 || timeout !== 1'b0) begin
      errors++; $display("FAIL novo_jogo actual st=%h rst=%b to=%b expected st=1 rst=1 to=0", db_estado, rst_dp, timeout);
    end
    novo_jogo = 1'b0;
    cyc();
    checks++;
    if (db_estado !== 4'h2) begin errors++; $display("FAIL novo_jogo_sel actual st=%h expected 2", db_estado); end
  endtask

  task automatic test_confirm_at_limit();
    repeat (TIMEOUT - 1) cyc();
    checks++;
    if (db_estado !== 4'h2) begin errors++; $display("FAIL limit_pre actual st=%h expected 2", db_estado); end
    confirmar = 1'b1;
    cyc();
    checks++;
    if (db_estado !== 4'h3 || timeout !== 1'b0) begin
      errors++; $display("FAIL confirm_at_limit actual st=%h to=%b expected st=3 to=0", db_estado, timeout);
    end
    confirmar = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic test_reset_mid();
    int n;
    novo_jogo = 1'b1;
    cyc();
    novo_jogo = 1'b0;
    cyc();
    repeat (7) cyc();
    reset = 1'b1;
    #1;
    checks++;
    if (rst_dp !== 1'b1 || db_estado !== 4'h2) begin
      errors++; $display("FAIL reset_mid_during actual st=%h rst=%b expected st=2 rst=1", db_estado, rst_dp);
    end
    cyc();
    reset = 1'b0;
    #1;
    checks++;
    if ({db_estado, botao_seed, rst_dp, zera_CS, e_seed_reg, pronto, timeout} !== 10'b0) begin
      errors++; $display("FAIL reset_mid_after actual st=%h rst=%b to=%b expected all 0", db_estado, rst_dp, timeout);
    end
    iniciar = 1'b1;
    cyc();
    iniciar = 1'b0;
    cyc();
    count_selection(n);
    checks++;
    if (n !== TIMEOUT || timeout !== 1'b1) begin
      errors++; $display("FAIL restart_timer actual cycles=%0d to=%b expected cycles=%0d to=1", n, timeout, TIMEOUT);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 63) == 0);
      iniciar   = ($urandom_range(0, 3) == 0);
      confirmar = ($urandom_range(0, 7) == 0);
      novo_jogo = ($urandom_range(0, 7) == 0);
      botao     = 1'($urandom);
      cyc();
    end
    reset = 1'b0; iniciar = 1'b0; confirmar = 1'b0; novo_jogo = 1'b0; botao = 1'b0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_start();
    test_confirm();
    test_timeout();
    test_jogo_ignore();
    test_confirm_at_limit();
    test_reset_mid();
    test_random();
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
